time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//   Free-running hours/minutes/seconds counter. It produces the hour/min/sec
//   values that the display conversion block (timeToNumber) consumes.
//   A 1 Hz tick is derived on-chip from the 50 MHz board clock.
//   A set mode lets the user edit one field at a time with inc/dec pulses
//   from debounced keys.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per second tick (>=2)
//   HOURS      24          hour modulus (12 or 24); hour runs 0..HOURS-1
// PORTS
//   clk        in   1  system clock
//   reset      in   1  synchronous reset, active-high
//   set_mode   in   1  1 = edit mode (time frozen), 0 = run mode
//   set_field  in   2  field to edit: 0 sec, 1 min, 2 hour, 3 none
//   inc        in   1  1-cycle pulse: add 1 to the selected field (set mode only)
//   dec        in   1  1-cycle pulse: subtract 1 from the selected field (set mode only)
//   hour       out  6  current hour, 0..HOURS-1
//   min        out  6  current minute, 0..59
//   sec        out  6  current second, 0..59
//   sec_pulse  out  1  1-cycle strobe, high in the cycle a run-mode second advance is visible
// BEHAVIOUR
//   Reset: reset is synchronous, active-high.
//   - While reset is high at a clk edge: hour = min = sec = 0, sec_pulse = 0,
//     prescaler = 0.
//   - Reset overrides set_mode, inc and dec.
//   Prescaler:
//   - Counts 0..TICK_DIV-1 every clk in run mode.
//   - An internal tick is asserted in the cycle the count equals TICK_DIV-1;
//     the count then wraps to 0.
//   - Width is $clog2(TICK_DIV).
//   Run mode (set_mode = 0):
//   - On tick, the registered outputs update at the next edge. Latency is
//     1 clk; sec_pulse is high in that same cycle.
//   - sec: 0..58 -> +1. sec 59 -> 0 and min advances.
//   - min: 59 -> 0 with a carry into hour.
//   - hour: HOURS-1 -> 0.
//   - 23:59:59 -> 00:00:00 in a single update (HOURS = 24).
//   - inc and dec are ignored.
//   Set mode (set_mode = 1):
//   - Prescaler is held at 0; tick and sec_pulse stay 0.
//   - inc: selected field +1 modulo its range (sec/min 60, hour HOURS).
//     No carry into any other field.
//   - dec: selected field -1 modulo its range; 0 -> max (59 or HOURS-1).
//     No borrow.
//   - inc and dec in the same cycle: no change.
//   - set_field = 3: inc and dec have no effect.
//   - Edits are visible 1 clk after the pulse.
//   Mode transitions:
//   - Entering set mode in the same cycle as a tick: set mode wins and the
//     tick is dropped.
//   - Leaving set mode: prescaler restarts from 0, so the first advance is
//     visible TICK_DIV+1 cycles after set_mode falls.
//   Outputs:
//   - All outputs are registered; no combinational paths from inputs.
//   - Output values never leave their legal ranges.
// TESTING (TICK_DIV = 4, HOURS = 24 unless noted)
//   1 reset high 3 clk, then run -> 00:00:00.
//     sec = 1 and sec_pulse = 1 one cycle after the 4th clk.
//     sec_pulse is high for exactly 1 cycle in every 4.
//   2 preset 00:00:59 via set mode, then run -> 00:01:00 after one tick.
//     Preset 23:59:59 -> 00:00:00 in a single update.
//   3 set mode, field 0 at 59, inc -> 0 with min unchanged.
//     Field 2 at 0, dec -> 23. With HOURS = 12: dec -> 11.
//   4 set mode with inc and dec both pulsed, and with field 3 + inc
//     -> all outputs unchanged. In run mode, inc pulses -> ignored.
//   5 raise set_mode in the cycle the tick fires -> no advance, sec_pulse = 0.
//     Drop set_mode -> next advance exactly 5 clk later.
//   6 assert reset at 12:34:56 during run -> 00:00:00 next edge.
//     Prescaler restarts: first sec_pulse 4 cycles after reset falls.

Source files
------------

// File: rtl/time_keeper.sv
// Hours/minutes/seconds keeper with an on-chip 1 Hz prescaler and a
// field-at-a-time set mode driven by debounced inc/dec pulses.
module time_keeper #(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOURS    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mode,
    input  logic [1:0] set_field,
    input  logic       inc,
    input  logic       dec,
    output logic [5:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [5:0]    SEC_MAX   = 6'd59;
    localparam logic [5:0]    HOUR_MAX  = 6'(HOURS - 1);

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2,
        FIELD_NONE = 2'd3
    } field_t;

    logic [PW-1:0] presc;
    logic          set_q;
    logic          tick;
    field_t        field;
    logic [5:0]    hour_n, min_n, sec_n;

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] maxv,
                                        input logic up);
        if (up) step = (v == maxv) ? 6'd0 : v + 6'd1;
        else    step = (v == 6'd0) ? maxv : v - 6'd1;
    endfunction

    assign field = field_t'(set_field);

    // set_q holds the prescaler for one settle cycle after leaving set mode,
    // so the first advance lands TICK_DIV+1 cycles after set_mode falls.
    assign tick = !set_mode && !set_q && (presc == PRESC_MAX);

    always_comb begin
        hour_n = hour;
        min_n  = min;
        sec_n  = sec;
        if (tick) begin
            sec_n = step(sec, SEC_MAX, 1'b1);
            if (sec == SEC_MAX) begin
                min_n = step(min, SEC_MAX, 1'b1);
                if (min == SEC_MAX)
                    hour_n = step(hour, HOUR_MAX, 1'b1);
            end
        end else if (set_mode && (inc ^ dec)) begin
            case (field)
                FIELD_SEC:  sec_n  = step(sec, SEC_MAX, inc);
                FIELD_MIN:  min_n  = step(min, SEC_MAX, inc);
                FIELD_HOUR: hour_n = step(hour, HOUR_MAX, inc);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            set_q     <= 1'b0;
            hour      <= 6'd0;
            min       <= 6'd0;
            sec       <= 6'd0;
            sec_pulse <= 1'b0;
        end else begin
            if (set_mode || set_q || tick)
                presc <= '0;
            else
                presc <= presc + PW'(1);
            set_q     <= set_mode;
            hour      <= hour_n;
            min       <= min_n;
            sec       <= sec_n;
            sec_pulse <= tick;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: a 24 h and a 12 h instance share stimulus;
// a time-of-day reference model predicts every cycle's outputs.
module tb_time_keeper;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_mode = 1'b0;
    logic [1:0] set_field = 2'd3;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic [5:0] hour, min, sec;
    logic       sec_pulse;
    logic [5:0] hour12, min12, sec12;
    logic       sec_pulse12;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int h24;
        int h12;
        int m;
        int s;
        int p;
    } exp_t;

    exp_t expq[$];

    // reference model state: time of day as fields, plus run-cycle bookkeeping
    int mh24 = 0, mh12 = 0, mm = 0, ms = 0, mp = 0;
    int runCycles = 0;
    bit prevSet = 1'b0;

    time_keeper #(.TICK_DIV(TICK_DIV), .HOURS(24)) dut (
        .clk(clk), .reset(reset), .set_mode(set_mode), .set_field(set_field),
        .inc(inc), .dec(dec), .hour(hour), .min(min), .sec(sec), .sec_pulse(sec_pulse)
    );

    time_keeper #(.TICK_DIV(TICK_DIV), .HOURS(12)) dut12 (
        .clk(clk), .reset(reset), .set_mode(set_mode), .set_field(set_field),
        .inc(inc), .dec(dec), .hour(hour12), .min(min12), .sec(sec12),
        .sec_pulse(sec_pulse12)
    );

    always #5 clk = ~clk;

    function automatic int secsOf(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic modelStep(input bit r, input bit sm, input int f, input bit i, input bit d);
        int t;
        int delta;
        if (r) begin
            mh24 = 0; mh12 = 0; mm = 0; ms = 0; mp = 0;
            runCycles = 0;
            prevSet = 1'b0;
        end else if (sm) begin
            mp = 0;
            runCycles = 0;
            prevSet = 1'b1;
            if (i != d) begin
                delta = i ? 1 : -1;
                case (f)
                    0: ms = (ms + delta + 60) % 60;
                    1: mm = (mm + delta + 60) % 60;
                    2: begin
                        mh24 = (mh24 + delta + 24) % 24;
                        mh12 = (mh12 + delta + 12) % 12;
                    end
                    default: ;
                endcase
            end
        end else if (prevSet) begin
            // one settle cycle after leaving set mode
            prevSet = 1'b0;
            mp = 0;
            runCycles = 0;
        end else begin
            runCycles++;
            mp = 0;
            if (runCycles % TICK_DIV == 0) begin
                mp = 1;
                t = (secsOf(mh12, mm, ms) + 1) % (12 * 3600);
                mh12 = t / 3600;
                t = (secsOf(mh24, mm, ms) + 1) % (24 * 3600);
                mh24 = t / 3600;
                mm = (t / 60) % 60;
                ms = t % 60;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit sm, input int f, input bit i, input bit d);
        exp_t e;
        reset = r;
        set_mode = sm;
        set_field = f[1:0];
        inc = i;
        dec = d;
        modelStep(r, sm, f, i, d);
        e.h24 = mh24; e.h12 = mh12; e.m = mm; e.s = ms; e.p = mp;
        expq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input int act, input int exp, input string name);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic runCycles_n(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 3, 1'b0, 1'b0);
    endtask

    task automatic editField(input int f, input bit up, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, f, up, !up);
    endtask

    // run until the 24 h instance strobes, bounded; check the cycle count
    task automatic waitPulse(input int expCycles, input string name);
        int n = 0;
        int found = 0;
        for (int k = 1; k <= 3 * TICK_DIV + 5; k++) begin
            applyStimulus(1'b0, 1'b0, 3, 1'b0, 1'b0);
            if (sec_pulse === 1'b1) begin
                n = k;
                found = 1;
                break;
            end
        end
        if (!found) n = -1;
        checkOutput(n, expCycles, name);
    endtask

    // monitor: pops one prediction per clock and compares both instances
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            tests++;
            if (hour !== 6'(e.h24) || min !== 6'(e.m) || sec !== 6'(e.s) ||
                sec_pulse !== 1'(e.p) || hour12 !== 6'(e.h12) || min12 !== 6'(e.m) ||
                sec12 !== 6'(e.s) || sec_pulse12 !== 1'(e.p)) begin
                fails++;
                $display("[TB] FAIL scoreboard @%0t: got %0d:%0d:%0d p%0d / %0d:%0d:%0d p%0d, expected %0d:%0d:%0d p%0d / %0d h12",
                         $time, hour, min, sec, sec_pulse, hour12, min12, sec12, sec_pulse12,
                         e.h24, e.m, e.s, e.p, e.h12);
            end
        end
    end

    initial begin
        #2;
        // 1: reset, then first strobe four edges later, then one per four
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        checkOutput(sec, 0, "reset_sec");
        waitPulse(4, "first_pulse_after_reset");
        checkOutput(sec, 1, "sec_after_first_tick");
        runCycles_n(12);

        // 2: 00:00:59 rolls to 00:01:00; 23:59:59 rolls to 00:00:00
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        editField(0, 1'b0, 1);
        waitPulse(5, "first_pulse_after_set");
        checkOutput(min, 1, "min_carry");
        checkOutput(sec, 0, "sec_wrap");
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        editField(0, 1'b0, 1);
        editField(1, 1'b0, 1);
        editField(2, 1'b0, 1);
        checkOutput(hour, 23, "preset_hour");
        checkOutput(hour12, 11, "preset_hour12");
        waitPulse(5, "midnight_pulse");
        checkOutput(secsOf(hour, min, sec), 0, "midnight_wrap");

        // 3: edit wrap without carry; hour dec from 0
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        editField(0, 1'b0, 1);
        editField(0, 1'b1, 1);
        checkOutput(min, 0, "no_carry_on_inc");
        editField(2, 1'b0, 1);
        checkOutput(hour, 23, "hour_dec_wrap24");
        checkOutput(hour12, 11, "hour_dec_wrap12");

        // 4: inc+dec together, field 3, and run-mode pulses all ignored
        applyStimulus(1'b0, 1'b1, 1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 3, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, k % 3, 1'b1, 1'b0);

        // 5: set_mode rises on the tick cycle -> dropped; first advance 5 later
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        runCycles_n(TICK_DIV - 1);
        applyStimulus(1'b0, 1'b1, 3, 1'b0, 1'b0);
        checkOutput(sec_pulse, 0, "tick_dropped_pulse");
        checkOutput(sec, 0, "tick_dropped_sec");
        waitPulse(5, "pulse_after_leave_set");

        // 6: reset mid-run at 12:34:56
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        editField(2, 1'b1, 12);
        editField(1, 1'b1, 34);
        editField(0, 1'b1, 56);
        runCycles_n(7);
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0);
        checkOutput(secsOf(hour, min, sec), 0, "reset_mid_run");
        waitPulse(4, "pulse_after_mid_reset");

        // randomized segments of run and set activity with rare resets
        for (int seg = 0; seg < 200; seg++) begin
            bit sm = ($urandom_range(0, 2) == 0);
            int len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                bit r = ($urandom_range(0, 99) == 0);
                applyStimulus(r, sm, $urandom_range(0, 3),
                              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            end
        end

        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
